// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of the single SRAM controller: grants, latches the command, tracks the ready handshake.
// Optional ROUND_ROBIN_EN: alternate simultaneous requests via lastGrant; otherwise master 0 has fixed priority.
module sram_arbiter #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0WrEnIn,
   input  logic        m0RdEnIn,
   input  logic [31:0] m0AddressIn,
   input  logic [31:0] m0WriteDataIn,
   output logic [31:0] m0ReadDataOut,
   output logic        m0ReadyOut,
   input  logic        m1WrEnIn,
   input  logic        m1RdEnIn,
   input  logic [31:0] m1AddressIn,
   input  logic [31:0] m1WriteDataIn,
   output logic [31:0] m1ReadDataOut,
   output logic        m1ReadyOut,
   output logic        memWrEnOut,
   output logic        memRdEnOut,
   output logic [31:0] memAddressOut,
   output logic [31:0] memWriteDataOut,
   input  logic [31:0] memReadDataIn,
   input  logic        memReadyIn
);

   localparam int CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, SETTLE} state_e;

   state_e            state_q, state_d;
   logic              grant_q, grant_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              cmdWr_q, cmdWr_d;
   logic              cmdRd_q, cmdRd_d;
   logic [31:0]       cmdAddr_q, cmdAddr_d;
   logic [31:0]       cmdData_q, cmdData_d;
   logic [31:0]       m0Held_q, m0Held_d;
   logic [31:0]       m1Held_q, m1Held_d;
`ifdef ROUND_ROBIN_EN
   logic              lastGrant_q, lastGrant_d;
`endif

   logic req0, req1, pick1, done, enActive;

   assign req0 = m0WrEnIn | m0RdEnIn;
   assign req1 = m1WrEnIn | m1RdEnIn;
   // Completion only counts in WAIT, so ready held high by the controller's trailing states is ignored.
   assign done = (state_q == WAIT) && memReadyIn;

`ifdef ROUND_ROBIN_EN
   assign pick1 = req1 & (~req0 | ~lastGrant_q);
`else
   assign pick1 = req1 & ~req0;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      cmdWr_d   = cmdWr_q;
      cmdRd_d   = cmdRd_q;
      cmdAddr_d = cmdAddr_q;
      cmdData_d = cmdData_q;
      m0Held_d  = m0Held_q;
      m1Held_d  = m1Held_q;
`ifdef ROUND_ROBIN_EN
      lastGrant_d = lastGrant_q;
`endif
      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               grant_d   = pick1;
               cmdWr_d   = pick1 ? m1WrEnIn : m0WrEnIn;
               cmdRd_d   = pick1 ? (m1RdEnIn & ~m1WrEnIn) : (m0RdEnIn & ~m0WrEnIn);
               cmdAddr_d = pick1 ? m1AddressIn : m0AddressIn;
               cmdData_d = pick1 ? m1WriteDataIn : m0WriteDataIn;
               state_d   = ISSUE;
`ifdef ROUND_ROBIN_EN
               lastGrant_d = pick1;
`endif
            end
         end
         ISSUE: begin
            if (!memReadyIn) state_d = WAIT;
         end
         WAIT: begin
            if (memReadyIn) begin
               if (SETTLE_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d   = CntW'(SETTLE_CYCLES);
                  state_d = SETTLE;
               end
            end
         end
         SETTLE: begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q <= CntW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (done && cmdRd_q) begin
         if (grant_q) m1Held_d = memReadDataIn;
         else         m0Held_d = memReadDataIn;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         cnt_q     <= '0;
         cmdWr_q   <= 1'b0;
         cmdRd_q   <= 1'b0;
         cmdAddr_q <= '0;
         cmdData_q <= '0;
         m0Held_q  <= '0;
         m1Held_q  <= '0;
`ifdef ROUND_ROBIN_EN
         lastGrant_q <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         cmdWr_q   <= cmdWr_d;
         cmdRd_q   <= cmdRd_d;
         cmdAddr_q <= cmdAddr_d;
         cmdData_q <= cmdData_d;
         m0Held_q  <= m0Held_d;
         m1Held_q  <= m1Held_d;
`ifdef ROUND_ROBIN_EN
         lastGrant_q <= lastGrant_d;
`endif
      end
   end

   // Enables drop in the completion cycle itself, not one cycle later.
   assign enActive        = (state_q == ISSUE) || ((state_q == WAIT) && !memReadyIn);
   assign memWrEnOut      = cmdWr_q & enActive;
   assign memRdEnOut      = cmdRd_q & enActive;
   assign memAddressOut   = (state_q == IDLE) ? 32'h0 : cmdAddr_q;
   assign memWriteDataOut = (state_q == IDLE) ? 32'h0 : cmdData_q;

   assign m0ReadyOut    = ~req0 | (done & ~grant_q);
   assign m1ReadyOut    = ~req1 | (done & grant_q);
   assign m0ReadDataOut = (done & ~grant_q) ? memReadDataIn : m0Held_q;
   assign m1ReadDataOut = (done & grant_q) ? memReadDataIn : m1Held_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed master traffic against a small SRAM controller model.
// Expects ROUND_ROBIN_EN to match the build of the design.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0WrEnIn, m0RdEnIn, m1WrEnIn, m1RdEnIn;
   logic [31:0] m0AddressIn, m0WriteDataIn, m1AddressIn, m1WriteDataIn;
   logic [31:0] m0ReadDataOut, m1ReadDataOut;
   logic        m0ReadyOut, m1ReadyOut;
   logic        memWrEnOut, memRdEnOut, memReadyIn;
   logic [31:0] memAddressOut, memWriteDataOut, memReadDataIn;

   typedef struct {
      int          master;
      int          cycle;
      logic [31:0] data;
      bit          isRead;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [2:0] ctlCnt;

   sram_arbiter dut (
      .clk(clk), .rst(rst),
      .m0WrEnIn(m0WrEnIn), .m0RdEnIn(m0RdEnIn), .m0AddressIn(m0AddressIn),
      .m0WriteDataIn(m0WriteDataIn), .m0ReadDataOut(m0ReadDataOut), .m0ReadyOut(m0ReadyOut),
      .m1WrEnIn(m1WrEnIn), .m1RdEnIn(m1RdEnIn), .m1AddressIn(m1AddressIn),
      .m1WriteDataIn(m1WriteDataIn), .m1ReadDataOut(m1ReadDataOut), .m1ReadyOut(m1ReadyOut),
      .memWrEnOut(memWrEnOut), .memRdEnOut(memRdEnOut), .memAddressOut(memAddressOut),
      .memWriteDataOut(memWriteDataOut), .memReadDataIn(memReadDataIn), .memReadyIn(memReadyIn)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Controller model: ready low while idle and for the first three enabled cycles, then high for three trailing cycles.
   always @(posedge clk or negedge rst) begin
      if (!rst)                                  ctlCnt <= 3'd0;
      else if (ctlCnt == 3'd0) begin
         if (memWrEnOut | memRdEnOut)            ctlCnt <= 3'd1;
      end else if (ctlCnt == 3'd5)               ctlCnt <= 3'd0;
      else                                       ctlCnt <= ctlCnt + 3'd1;
   end

   function automatic logic [31:0] dataFor(input logic [31:0] addr);
      return (addr == 32'h0000_0404) ? 32'hDEAD_BEEF : ~addr;
   endfunction

   assign memReadyIn    = (ctlCnt >= 3'd3);
   assign memReadDataIn = (ctlCnt == 3'd3) ? dataFor(memAddressOut) : 32'h0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input int m, input logic wr, input logic rd,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         m0WrEnIn = wr; m0RdEnIn = rd; m0AddressIn = addr; m0WriteDataIn = wdata;
      end else begin
         m1WrEnIn = wr; m1RdEnIn = rd; m1AddressIn = addr; m1WriteDataIn = wdata;
      end
   endtask

   task automatic pushExp(input int m, input int c, input logic [31:0] d, input bit rd);
      exp_t e;
      e.master = m; e.cycle = c; e.data = d; e.isRead = rd;
      sbQ.push_back(e);
   endtask

   task automatic gotoDrive(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gotoSample(input int c);
      gotoDrive(c);
      @(negedge clk);
   endtask

   task automatic popAndCompare(input int m, input logic [31:0] data);
      exp_t e;
      if (sbQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpectedDone: master %0d completed at cycle %0d, none expected", m, cyc);
      end else begin
         e = sbQ.pop_front();
         checkOutput("doneMaster", m, e.master);
         checkOutput("doneCycle", cyc, e.cycle);
         if (e.isRead) checkOutput("doneData", data, e.data);
      end
   endtask

   // Monitor: a master with its request up and ready high has just seen its completion.
   always @(negedge clk) begin
      if ((m0WrEnIn | m0RdEnIn) && m0ReadyOut) popAndCompare(0, m0ReadDataOut);
      if ((m1WrEnIn | m1RdEnIn) && m1ReadyOut) popAndCompare(1, m1ReadDataOut);
   end

   initial begin
      int b;
      rst = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      checkOutput("rstWrEn", memWrEnOut, 0);
      checkOutput("rstRdEn", memRdEnOut, 0);
      checkOutput("rstAddr", memAddressOut, 0);
      checkOutput("rstWData", memWriteDataOut, 0);
      checkOutput("rstReady0Idle", m0ReadyOut, 1);
      checkOutput("rstRData0", m0ReadDataOut, 0);
      m0RdEnIn = 1'b1;
      #1;
      checkOutput("rstReady0Req", m0ReadyOut, 0);
      m0RdEnIn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      gotoDrive(cyc + 1);

      $display("[TB] master 0 read, no contention");
      b = cyc;
      applyStimulus(0, 1'b0, 1'b1, 32'h0000_0404, 32'h0);
      pushExp(0, b + 4, 32'hDEAD_BEEF, 1);
      gotoSample(b);
      checkOutput("t1ReadyC0", m0ReadyOut, 0);
      gotoSample(b + 1);
      checkOutput("t1RdEnC1", memRdEnOut, 1);
      checkOutput("t1WrEnC1", memWrEnOut, 0);
      checkOutput("t1AddrC1", memAddressOut, 32'h0000_0404);
      gotoSample(b + 3);
      checkOutput("t1ReadyC3", m0ReadyOut, 0);
      gotoDrive(b + 5);
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      gotoSample(b + 5);
      checkOutput("t1HeldC5", m0ReadDataOut, 32'hDEAD_BEEF);
      checkOutput("t1RdEnC5", memRdEnOut, 0);
      gotoSample(b + 6);
      checkOutput("t1AddrSettle", memAddressOut, 32'h0000_0404);
      gotoSample(b + 7);
      checkOutput("t1AddrIdle", memAddressOut, 32'h0);
      gotoDrive(b + 8);

      $display("[TB] master 1 write");
      b = cyc;
      applyStimulus(1, 1'b1, 1'b0, 32'h0000_0800, 32'h1234_5678);
      pushExp(1, b + 4, 32'h0, 0);
      gotoSample(b + 1);
      checkOutput("t2WrEnC1", memWrEnOut, 1);
      checkOutput("t2RdEnC1", memRdEnOut, 0);
      checkOutput("t2AddrC1", memAddressOut, 32'h0000_0800);
      checkOutput("t2WDataC1", memWriteDataOut, 32'h1234_5678);
      checkOutput("t2ReadyC1", m1ReadyOut, 0);
      gotoSample(b + 3);
      checkOutput("t2WrEnC3", memWrEnOut, 1);
      checkOutput("t2RdEnC3", memRdEnOut, 0);
      gotoSample(b + 4);
      checkOutput("t2WrEnC4", memWrEnOut, 0);
      checkOutput("t2RdEnC4", memRdEnOut, 0);
      gotoDrive(b + 5);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      gotoDrive(b + 7);

      $display("[TB] both masters reading continuously");
      b = cyc;
      applyStimulus(0, 1'b0, 1'b1, 32'h0000_0100, 32'h0);
      applyStimulus(1, 1'b0, 1'b1, 32'h0000_0200, 32'h0);
`ifdef ROUND_ROBIN_EN
      pushExp(0, b + 4,  32'hFFFF_FEFF, 1);
      pushExp(1, b + 11, 32'hFFFF_FDFF, 1);
      pushExp(0, b + 18, 32'hFFFF_FEFF, 1);
      pushExp(1, b + 25, 32'hFFFF_FDFF, 1);
`else
      pushExp(0, b + 4,  32'hFFFF_FEFF, 1);
      pushExp(0, b + 11, 32'hFFFF_FEFF, 1);
      pushExp(0, b + 18, 32'hFFFF_FEFF, 1);
      pushExp(0, b + 25, 32'hFFFF_FEFF, 1);
`endif
      gotoSample(b + 4);
      checkOutput("t3Ready1C4", m1ReadyOut, 0);
      gotoSample(b + 8);
`ifdef ROUND_ROBIN_EN
      checkOutput("t3AddrC8", memAddressOut, 32'h0000_0200);
      gotoSample(b + 11);
      checkOutput("t3Ready0C11", m0ReadyOut, 0);
      gotoSample(b + 12);
      checkOutput("t3Held1C12", m1ReadDataOut, 32'hFFFF_FDFF);
`else
      checkOutput("t3AddrC8", memAddressOut, 32'h0000_0100);
      gotoSample(b + 11);
      checkOutput("t3Ready1C11", m1ReadyOut, 0);
      gotoSample(b + 12);
      checkOutput("t3Held1C12", m1ReadDataOut, 32'h0);
`endif
      checkOutput("t3Held0C12", m0ReadDataOut, 32'hFFFF_FEFF);
      gotoSample(b + 25);
`ifdef ROUND_ROBIN_EN
      checkOutput("t3Ready0C25", m0ReadyOut, 0);
`else
      checkOutput("t3Ready1C25", m1ReadyOut, 0);
`endif
      gotoDrive(b + 26);
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      gotoDrive(b + 28);

      $display("[TB] master 0 drops a write mid-transaction");
      b = cyc;
      applyStimulus(0, 1'b1, 1'b0, 32'h0000_0300, 32'hCAFE_F00D);
      pushExp(1, b + 11, 32'hFFFF_FAFF, 1);
      gotoDrive(b + 2);
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b1, 32'h0000_0500, 32'h0);
      gotoSample(b + 2);
      checkOutput("t4WrEnC2", memWrEnOut, 1);
      checkOutput("t4WDataC2", memWriteDataOut, 32'hCAFE_F00D);
      checkOutput("t4Ready0C2", m0ReadyOut, 1);
      checkOutput("t4Ready1C2", m1ReadyOut, 0);
      gotoSample(b + 3);
      checkOutput("t4WrEnC3", memWrEnOut, 1);
      gotoSample(b + 4);
      checkOutput("t4WrEnC4", memWrEnOut, 0);
      gotoSample(b + 5);
      checkOutput("t4RdEnC5", memRdEnOut, 0);
      checkOutput("t4Held0C5", m0ReadDataOut, 32'hFFFF_FEFF);
      gotoSample(b + 7);
      checkOutput("t4RdEnC7", memRdEnOut, 0);
      checkOutput("t4Ready1C7", m1ReadyOut, 0);
      gotoSample(b + 8);
      checkOutput("t4RdEnC8", memRdEnOut, 1);
      checkOutput("t4AddrC8", memAddressOut, 32'h0000_0500);
      gotoDrive(b + 12);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      gotoDrive(b + 14);

      $display("[TB] reset during WAIT");
      b = cyc;
      applyStimulus(0, 1'b0, 1'b1, 32'h0000_0600, 32'h0);
      pushExp(1, b + 7, 32'hFFFF_F8FF, 1);
      gotoSample(b + 1);
      checkOutput("t5RdEnC1", memRdEnOut, 1);
      checkOutput("t5AddrC1", memAddressOut, 32'h0000_0600);
      gotoDrive(b + 2);
      rst = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b1, 32'h0000_0700, 32'h0);
      #1;
      checkOutput("t5RdEnRst", memRdEnOut, 0);
      checkOutput("t5WrEnRst", memWrEnOut, 0);
      checkOutput("t5AddrRst", memAddressOut, 32'h0);
      checkOutput("t5WDataRst", memWriteDataOut, 32'h0);
      gotoSample(b + 2);
      checkOutput("t5Held0Rst", m0ReadDataOut, 32'h0);
      checkOutput("t5Ready1Rst", m1ReadyOut, 0);
      gotoDrive(b + 3);
      rst = 1'b1;
      gotoSample(b + 3);
      checkOutput("t5RdEnC3", memRdEnOut, 0);
      gotoSample(b + 4);
      checkOutput("t5RdEnC4", memRdEnOut, 1);
      checkOutput("t5AddrC4", memAddressOut, 32'h0000_0700);
      gotoDrive(b + 8);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      gotoSample(b + 11);

      checkOutput("sbEmpty", sbQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master arbiter that shares the single SRAM controller between the MEM-stage data port (master 0) and a secondary requester such as a write buffer or DMA (master 1). It grants one master at a time, latches that master's command, sequences the controller's ready protocol, and returns read data and a one-cycle completion to the granted master. Sits between the requesters and the SRAM controller; master ready outputs feed pipeline freeze logic.

## Interface
- SETTLE_CYCLES, 2, idle cycles after completion while the controller drains its trailing states (UP_HIGH, DONE) back to IDLE
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- m0WrEnIn, m0RdEnIn  in  1 each  master 0 write/read request, level, held until m0ReadyOut
- m0AddressIn  in  32  master 0 byte address
- m0WriteDataIn  in  32  master 0 write data
- m0ReadDataOut  out  32  master 0 read data
- m0ReadyOut  out  1  master 0 ready (low = freeze)
- m1WrEnIn, m1RdEnIn, m1AddressIn, m1WriteDataIn, m1ReadDataOut, m1ReadyOut  same as master 0
- memWrEnOut, memRdEnOut  out  1 each  controller write/read enable
- memAddressOut  out  32  controller address
- memWriteDataOut  out  32  controller write data
- memReadDataIn  in  32  controller read data
- memReadyIn  in  1  controller ready

## Operation
- Request per master: req = wrEn | rdEn. If both wrEn and rdEn are high, write wins; the grant latches wr = 1, rd = 0.
- States: IDLE, ISSUE, WAIT, SETTLE. A registered grant bit selects master 0 or 1. A lastGrant bit records the last master served.
- IDLE: if any request is pending, pick a winner. Latch its address, write data and wr/rd type into command registers, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: drive mem enables from the latched type. When memReadyIn == 0, go to WAIT.
- WAIT: keep driving the enables. The first cycle with memReadyIn == 1 is the completion cycle ("done"). In that cycle, drop the enables and load the settle counter with SETTLE_CYCLES, then go to SETTLE. If SETTLE_CYCLES == 0, go straight to IDLE.
- SETTLE: enables low; decrement the counter; when it reaches 1, go to IDLE.
- memAddressOut and memWriteDataOut come from the command registers. They are 0 in IDLE.
- Master ready:
  - mXReadyOut = ~reqX | (done & grant == X).
  - A pending, unfinished request holds ready low, including a request that lost arbitration.
- Read data:
  - mXReadDataOut = memReadDataIn during done for the granted master, otherwise the per-master held register.
  - Each master's register is loaded at done on its own reads only.
- Arbitration on simultaneous requests in IDLE: the master not equal to lastGrant wins. lastGrant updates at grant.
- A master that drops its request mid-transaction does not abort it. The latched command completes, and read data still loads the held register.
- A new request on the cycle after done is a new transaction.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE; grant = 0; lastGrant = 1; counter = 0.
  - Command registers and held read data = 0.
  - memWrEnOut, memRdEnOut = 0; memAddressOut, memWriteDataOut = 0.
  - mXReadyOut = ~reqX (combinational).
- Reset mid-transaction: return to IDLE immediately with enables low. The controller is reset from the same system reset.
- Single uncontested access, request seen in IDLE at cycle 0:
  - cycle 1: ISSUE, enables high.
  - cycle 2: WAIT.
  - cycle 4: controller ready rises, done; ready and data reach the master.
  - cycles 5–6: SETTLE.
  - cycle 7: IDLE.
- Service interval: a request waiting in IDLE at cycle 7 is issued at cycle 8. Minimum back-to-back service period is 7 cycles with the default parameter.
- The controller's ready being high in trailing states is never mistaken for completion, because done requires ISSUE to have seen ready low first.
- The done pulse lasts exactly one cycle per transaction.

## Configuration
- ROUND_ROBIN_EN defined: simultaneous requests alternate using lastGrant, as described above.
- ROUND_ROBIN_EN undefined: fixed priority, master 0 always wins simultaneous requests. lastGrant is not implemented, and master 1 can starve.

## Test plan
- Master 0 read at 0x0000_0404, no contention, controller returns 0xDEADBEEF: ISSUE at cycle 1, m0ReadyOut high only at cycle 4, m0ReadDataOut = 0xDEADBEEF at cycle 4 and held afterwards, IDLE at cycle 7.
- Master 1 write of 0x1234_5678 to 0x0000_0800: memWrEnOut high cycles 1–3, memAddressOut = 0x800, memWriteDataOut = 0x12345678 while enabled; m1ReadyOut pulses at cycle 4; memRdEnOut never asserts.
- Both masters request reads continuously with ROUND_ROBIN_EN: grants go 0, 1, 0, 1; completions 7 cycles apart; the waiting master's ready stays low until its own done.
- Same stimulus without ROUND_ROBIN_EN: every grant goes to master 0; m1ReadyOut stays low.
- Master 0 drops its request at cycle 2 of a write: enables persist until done and the write completes; the next grant waits until IDLE.
- rst pulled low during WAIT: all mem outputs go 0 immediately; after release, state is IDLE and a pending master 1 request is issued 1 cycle later.
